// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - states, opcodes, select codes and per-state control decode for multicycle_ctrl
// JAL_EN enables decode of the JAL state outputs.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_IFN = 2'b11;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       busy;
    logic       illegal;
  } ctrl_t;

  // Moore part of the outputs; pc_en here covers only the unconditional JAL load.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.alu_op = ALU_ADD; end
      S_DECODE:  begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      S_MEMADR:  begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = WB_MDR; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_EXEC_R:  begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALU_RFN; end
      S_EXEC_I:  begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_IFN; end
      S_ALUWB:   begin c.reg_write = 1'b1; c.mem_to_reg = WB_ALUOUT; end
      S_BRANCH:  begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALU_BR; c.pc_src = 1'b1; end
`ifdef JAL_EN
      S_JAL:     begin c.reg_write = 1'b1; c.mem_to_reg = WB_PC; c.pc_en = 1'b1; c.pc_src = 1'b1; end
`endif
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c = '0;
    endcase
    c.busy = (s != S_IDLE) && (s != S_ILLEGAL);
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// rtl/multicycle_ctrl_branch_cond.sv - branch taken decision from funct3 and ALU flags
module branch_cond
  import multicycle_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       alu_lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = zero;
      3'b001:         taken = ~zero;
      3'b100, 3'b110: taken = alu_lt;
      3'b101, 3'b111: taken = ~alu_lt;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with ready-handshaked shared memory
// Optional JAL support is built when JAL_EN is defined.
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       alu_lt,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic       busy,
  output logic       illegal
);

  state_t state, state_d, next_instr;
  ctrl_t  ctrl;
  logic   taken;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .alu_lt (alu_lt),
    .taken  (taken)
  );

  // Instruction boundary: park in IDLE instead of fetching when run is low.
  assign next_instr = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = (funct3 == 3'b010 || funct3 == 3'b011) ? S_ILLEGAL : S_BRANCH;
`ifdef JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = next_instr;
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: state_d = next_instr;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_d;
      ctrl  <= ctrl_decode(state_d);
    end
  end

  assign ir_write   = (state == S_FETCH) & mem_ready;
  assign pc_en      = ctrl.pc_en | ir_write | ((state == S_BRANCH) & taken);
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign busy       = ctrl.busy;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl (vector table plus corner sequences)
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, alu_lt = 1'b0, mem_ready = 1'b0;
  logic pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write, pc_src, busy, illegal;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
    .zero(zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, busy, illegal};

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    int          cyc;
    int          pcs;
    int          rws;
    int          mws;
    logic        ill;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];
  vec_t        sb_q[$];
  vec_t        vecs[16];

  logic [16:0] w_idle, w_fetch_rdy, w_fetch_wait, w_decode, w_memadr, w_memrd, w_memwb;
  logic [16:0] w_exec_r, w_aluwb, w_jal, w_ill;

  function automatic logic [16:0] mk(input logic pe, irw, iod, mr, mw, rw,
                                     input logic [1:0] m2r, sa, sb, op,
                                     input logic ps, bz, il);
    return {pe, irw, iod, mr, mw, rw, m2r, sa, sb, op, ps, bz, il};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // One clock: drive mem_ready just after the edge, compare at the falling edge.
  task automatic step(input logic mr, input logic [16:0] want, input string name);
    logic [16:0] e;
    @(posedge clk);
    #1 mem_ready = mr;
    exp_q.push_back(want);
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, 32'(obs), 32'(e));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_instr(input logic [31:0] instr);
    opcode = instr[6:0];
    funct3 = instr[14:12];
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc = 0, pcs = 0, rws = 0, mws = 0, clash = 0;
    logic seen = 1'b0, done = 1'b0;
    vec_t e;
    apply_reset();
    set_instr(v.instr);
    zero = v.zero;
    alu_lt = v.lt;
    mem_ready = 1'b1;
    run = 1'b1;
    sb_q.push_back(v);
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (mem_read && mem_write) clash++;
      if (busy) begin
        seen = 1'b1;
        run = 1'b0;
        cyc++;
        pcs += int'(pc_en);
        rws += int'(reg_write);
        mws += int'(mem_write);
      end else if (seen) begin
        done = 1'b1;
      end
    end
    e = sb_q.pop_front();
    check($sformatf("v%0d finished", idx), 32'(done), 32'd1);
    check($sformatf("v%0d cycles", idx), 32'(cyc), 32'(e.cyc));
    check($sformatf("v%0d pc_en pulses", idx), 32'(pcs), 32'(e.pcs));
    check($sformatf("v%0d reg_write pulses", idx), 32'(rws), 32'(e.rws));
    check($sformatf("v%0d mem_write pulses", idx), 32'(mws), 32'(e.mws));
    check($sformatf("v%0d illegal", idx), 32'(illegal), 32'(e.ill));
    check($sformatf("v%0d strobe clash", idx), 32'(clash), 32'd0);
  endtask

  initial begin
    int pcs;

    w_idle       = '0;
    w_fetch_rdy  = mk(1,1,0,1,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0,1,0);
    w_fetch_wait = mk(0,0,0,1,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0,1,0);
    w_decode     = mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 0,1,0);
    w_memadr     = mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0,1,0);
    w_memrd      = mk(0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1,0);
    w_memwb      = mk(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 0,1,0);
    w_exec_r     = mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 2'b10, 0,1,0);
    w_aluwb      = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0,1,0);
    w_jal        = mk(1,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 1,1,0);
    w_ill        = mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0,1);

    //            instr          z     lt    cyc pc rw mw ill
    vecs[0]  = '{32'h002081B3, 1'b0, 1'b0, 4, 1, 1, 0, 1'b0};  // add
    vecs[1]  = '{32'h00500093, 1'b0, 1'b0, 4, 1, 1, 0, 1'b0};  // addi
    vecs[2]  = '{32'h0000A283, 1'b0, 1'b0, 5, 1, 1, 0, 1'b0};  // lw
    vecs[3]  = '{32'h0020A223, 1'b0, 1'b0, 4, 1, 0, 1, 1'b0};  // sw
    vecs[4]  = '{32'h00208463, 1'b1, 1'b0, 3, 2, 0, 0, 1'b0};  // beq taken
    vecs[5]  = '{32'h00208463, 1'b0, 1'b0, 3, 1, 0, 0, 1'b0};  // beq not taken
    vecs[6]  = '{32'h00209463, 1'b1, 1'b0, 3, 1, 0, 0, 1'b0};  // bne zero=1
    vecs[7]  = '{32'h00209463, 1'b0, 1'b0, 3, 2, 0, 0, 1'b0};  // bne zero=0
    vecs[8]  = '{32'h0020C463, 1'b0, 1'b1, 3, 2, 0, 0, 1'b0};  // blt lt=1
    vecs[9]  = '{32'h0020D463, 1'b0, 1'b1, 3, 1, 0, 0, 1'b0};  // bge lt=1
    vecs[10] = '{32'h0020E463, 1'b0, 1'b0, 3, 1, 0, 0, 1'b0};  // bltu lt=0
    vecs[11] = '{32'h0020F463, 1'b0, 1'b0, 3, 2, 0, 0, 1'b0};  // bgeu lt=0
    vecs[12] = '{32'h0020A463, 1'b0, 1'b0, 2, 1, 0, 0, 1'b1};  // branch funct3=010
    vecs[13] = '{32'h0020B463, 1'b0, 1'b0, 2, 1, 0, 0, 1'b1};  // branch funct3=011
    vecs[14] = '{32'h0000007F, 1'b0, 1'b0, 2, 1, 0, 0, 1'b1};  // unknown opcode
`ifdef JAL_EN
    vecs[15] = '{32'h008000EF, 1'b0, 1'b0, 3, 2, 1, 0, 1'b0};  // jal
`else
    vecs[15] = '{32'h008000EF, 1'b0, 1'b0, 2, 1, 0, 0, 1'b1};  // jal without support
`endif

    // Reset state, then idle with run low.
    apply_reset();
    @(negedge clk);
    check("reset outputs", 32'(obs), 32'(w_idle));
    step(0, w_idle, "idle run=0");

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // R-type cycle by cycle.
    apply_reset();
    set_instr(32'h002081B3);
    run = 1'b1;
    step(1, w_fetch_rdy, "r fetch");
    run = 1'b0;
    step(1, w_decode, "r decode");
    step(1, w_exec_r, "r exec");
    step(1, w_aluwb, "r aluwb");
    step(1, w_idle, "r idle");

    // Load with 2 FETCH waits and 3 MEMRD waits: 10 busy cycles, one pc_en pulse.
    apply_reset();
    set_instr(32'h0000A283);
    run = 1'b1;
    pcs = 0;
    step(0, w_fetch_wait, "ld fetch wait1");  pcs += int'(pc_en);
    run = 1'b0;
    step(0, w_fetch_wait, "ld fetch wait2");  pcs += int'(pc_en);
    step(1, w_fetch_rdy, "ld fetch rdy");     pcs += int'(pc_en);
    step(1, w_decode, "ld decode");           pcs += int'(pc_en);
    step(1, w_memadr, "ld memadr");           pcs += int'(pc_en);
    step(0, w_memrd, "ld memrd wait1");       pcs += int'(pc_en);
    step(0, w_memrd, "ld memrd wait2");       pcs += int'(pc_en);
    step(0, w_memrd, "ld memrd wait3");       pcs += int'(pc_en);
    step(1, w_memrd, "ld memrd rdy");         pcs += int'(pc_en);
    step(1, w_memwb, "ld memwb");             pcs += int'(pc_en);
    step(1, w_idle, "ld idle");
    check("ld pc_en pulses", 32'(pcs), 32'd1);

    // Reset asserted in the middle of a wait-stated MEMRD.
    apply_reset();
    set_instr(32'h0000A283);
    run = 1'b1;
    step(1, w_fetch_rdy, "rr fetch");
    step(1, w_decode, "rr decode");
    step(1, w_memadr, "rr memadr");
    step(0, w_memrd, "rr memrd");
    rst = 1'b0;
    #1 check("rr async clear", 32'(obs), 32'(w_idle));
    run = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    step(1, w_idle, "rr idle1");
    step(1, w_idle, "rr idle2");

    // Illegal opcode is terminal regardless of run.
    apply_reset();
    set_instr(32'h0000007F);
    run = 1'b1;
    step(1, w_fetch_rdy, "il fetch");
    step(1, w_decode, "il decode");
    step(1, w_ill, "il enter");
    for (int k = 0; k < 4; k++) begin
      run = k[0];
      step(1, w_ill, $sformatf("il hold%0d", k));
    end
    rst = 1'b0;
    #1 check("il reset clears", 32'(obs), 32'(w_idle));

    // JAL, with or without support.
    apply_reset();
    set_instr(32'h008000EF);
    run = 1'b1;
    step(1, w_fetch_rdy, "jal fetch");
    run = 1'b0;
    step(1, w_decode, "jal decode");
`ifdef JAL_EN
    step(1, w_jal, "jal exec");
    step(1, w_idle, "jal idle");
`else
    step(1, w_ill, "jal illegal");
    check("jal m2r unused", 32'(w_jal[10:9]), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
